// File: rtl/keypress_display_ctrl_if.sv
// Scan-code byte stream from the PS/2 receiver into the keypress controller.
// A byte transfers on a rising edge where code_valid and code_ready are both high; the sender holds code_data and code_valid until then.
interface keypress_display_ctrl_if;
    logic [7:0] code_data;
    logic       code_valid;
    logic       code_ready;

    modport master (output code_data, output code_valid, input code_ready);
    modport slave  (input code_data, input code_valid, output code_ready);
endinterface

// File: rtl/keypress_display_ctrl.sv
// Decodes PS/2 make/break/E0 sequences, suppresses typematic repeats and keeps a press counter.
// Optional macro PRESS_SAT_EN: press counter saturates at MAX_COUNT instead of wrapping to 0.
module keypress_display_ctrl #(
    parameter int MAX_COUNT = 99
) (
    input  logic                    clk,
    input  logic                    clrn,
    keypress_display_ctrl_if.slave  code_if,
    input  logic                    count_clr,
    output logic [6:0]              press_count,
    output logic [7:0]              cur_code,
    output logic                    cur_ext,
    output logic                    key_held,
    output logic                    disp_en,
    output logic [2:0]              state_dbg
);
    typedef enum logic [2:0] {S_IDLE, S_E0, S_BRK, S_EBRK, S_UPD} state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [6:0] MAX_C   = 7'(MAX_COUNT);

    state_t     state, state_n;
    logic [7:0] lat_code, lat_code_n;
    logic       lat_ext, lat_ext_n;
    logic       lat_brk, lat_brk_n;
    logic       hs;
    logic       same_key;
    logic       count_inc;
    logic       held_clr;
    logic [6:0] count_next;

    assign code_if.code_ready = clrn && (state != S_UPD);
    assign hs        = code_if.code_valid && code_if.code_ready;
    assign state_dbg = state;

    always_comb begin
        state_n    = state;
        lat_code_n = lat_code;
        lat_ext_n  = lat_ext;
        lat_brk_n  = lat_brk;
        case (state)
            S_IDLE: if (hs) begin
                if (code_if.code_data == BYTE_E0)      state_n = S_E0;
                else if (code_if.code_data == BYTE_F0) state_n = S_BRK;
                else begin
                    lat_code_n = code_if.code_data;
                    lat_ext_n  = 1'b0;
                    lat_brk_n  = 1'b0;
                    state_n    = S_UPD;
                end
            end
            S_E0: if (hs) begin
                if (code_if.code_data == BYTE_F0)      state_n = S_EBRK;
                else if (code_if.code_data == BYTE_E0) state_n = S_E0;
                else begin
                    lat_code_n = code_if.code_data;
                    lat_ext_n  = 1'b1;
                    lat_brk_n  = 1'b0;
                    state_n    = S_UPD;
                end
            end
            S_BRK, S_EBRK: if (hs) begin
                // A prefix right after F0 is malformed: drop it and resync.
                if (code_if.code_data == BYTE_E0 || code_if.code_data == BYTE_F0) begin
                    state_n = S_IDLE;
                end else begin
                    lat_code_n = code_if.code_data;
                    lat_ext_n  = (state == S_EBRK);
                    lat_brk_n  = 1'b1;
                    state_n    = S_UPD;
                end
            end
            S_UPD:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign same_key  = (lat_code == cur_code) && (lat_ext == cur_ext);
    assign count_inc = (state == S_UPD) && !lat_brk && !(key_held && same_key);
    assign held_clr  = (state == S_UPD) && lat_brk && same_key;

`ifdef PRESS_SAT_EN
    assign count_next = (press_count == MAX_C) ? MAX_C : press_count + 7'd1;
`else
    assign count_next = (press_count == MAX_C) ? 7'd0 : press_count + 7'd1;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= S_IDLE;
            lat_code    <= 8'h00;
            lat_ext     <= 1'b0;
            lat_brk     <= 1'b0;
            press_count <= 7'd0;
            cur_code    <= 8'h00;
            cur_ext     <= 1'b0;
            key_held    <= 1'b0;
            disp_en     <= 1'b0;
        end else begin
            state    <= state_n;
            lat_code <= lat_code_n;
            lat_ext  <= lat_ext_n;
            lat_brk  <= lat_brk_n;
            // Clear beats a coinciding increment; the key state still updates.
            if (count_clr)      press_count <= 7'd0;
            else if (count_inc) press_count <= count_next;
            if (count_inc) begin
                cur_code <= lat_code;
                cur_ext  <= lat_ext;
                key_held <= 1'b1;
                disp_en  <= 1'b1;
            end else if (held_clr) begin
                key_held <= 1'b0;
                disp_en  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypress_display_ctrl.sv
// Scoreboard bench for keypress_display_ctrl: a behavioural key model predicts the outputs after each byte.
module tb_keypress_display_ctrl;
  localparam int MAX_COUNT = 99;
  localparam int W = 18;

  logic       clk;
  logic       clrn;
  logic       count_clr;
  logic [6:0] press_count;
  logic [7:0] cur_code;
  logic       cur_ext;
  logic       key_held;
  logic       disp_en;
  logic [2:0] state_dbg;

  keypress_display_ctrl_if kif ();

  keypress_display_ctrl #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .code_if     (kif.slave),
    .count_clr   (count_clr),
    .press_count (press_count),
    .cur_code    (cur_code),
    .cur_ext     (cur_ext),
    .key_held    (key_held),
    .disp_en     (disp_en),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // key model
  int         m_st;      // 0 idle, 1 after E0, 2 after F0, 3 after E0 F0
  logic [6:0] m_count;
  logic [7:0] m_code;
  logic       m_ext;
  logic       m_held;

  function automatic logic [W-1:0] pack(input logic [6:0] c, input logic [7:0] k,
                                        input logic e, input logic h, input logic d);
    return {c, k, e, h, d};
  endfunction

  task automatic model_reset();
    m_st = 0; m_count = 7'd0; m_code = 8'h00; m_ext = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] k, input logic e, input bit brk, input bit clr);
    if (!brk) begin
      if (!(m_held && k == m_code && e == m_ext)) begin
        m_code = k; m_ext = e; m_held = 1'b1;
`ifdef PRESS_SAT_EN
        if (m_count != 7'(MAX_COUNT)) m_count = m_count + 7'd1;
`else
        m_count = (m_count == 7'(MAX_COUNT)) ? 7'd0 : m_count + 7'd1;
`endif
      end
    end else if (k == m_code && e == m_ext) begin
      m_held = 1'b0;
    end
    if (clr) m_count = 7'd0;
  endtask

  // returns 1 when b completes a make or break
  task automatic model_byte(input logic [7:0] b, input bit clr, output bit term);
    term = 1'b0;
    case (m_st)
      0: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 2;
         else begin model_commit(b, 1'b0, 1'b0, clr); term = 1'b1; m_st = 0; end
      1: if (b == 8'hF0) m_st = 3; else if (b == 8'hE0) m_st = 1;
         else begin model_commit(b, 1'b1, 1'b0, clr); term = 1'b1; m_st = 0; end
      default: begin
        if (b == 8'hE0 || b == 8'hF0) m_st = 0;
        else begin model_commit(b, (m_st == 3), 1'b1, clr); term = 1'b1; m_st = 0; end
      end
    endcase
  endtask

  // driver: one byte, with optional count_clr pulse on the commit edge
  task automatic send(input logic [7:0] b, input bit clr);
    int n;
    bit term;
    logic [W-1:0] exp;
    @(negedge clk);
    n = 0;
    while (!kif.code_ready && n < 20) begin @(negedge clk); n++; end
    if (!kif.code_ready) begin
      check("ready_timeout", 32'(kif.code_ready), 32'd1);
      return;
    end
    kif.code_data  = b;
    kif.code_valid = 1'b1;
    @(posedge clk);
    #1;
    kif.code_valid = 1'b0;
    kif.code_data  = $urandom_range(0, 255);
    model_byte(b, clr, term);
    exp_q.push_back(pack(m_count, m_code, m_ext, m_held, m_held));
    @(negedge clk);
    if (term) begin
      check("ready_low_upd", 32'(kif.code_ready), 32'd0);
      if (clr) count_clr = 1'b1;
      @(posedge clk);
      #1;
      count_clr = 1'b0;
      @(negedge clk);
    end else begin
      check("ready_after_pfx", 32'(kif.code_ready), 32'd1);
    end
    exp = exp_q.pop_front();
    check($sformatf("outs_%02h", b), 32'(pack(press_count, cur_code, cur_ext, key_held, disp_en)), 32'(exp));
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    count_clr = 1'b1;
    @(posedge clk);
    #1;
    count_clr = 1'b0;
    m_count = 7'd0;
    @(negedge clk);
    check("count_clr_alone", 32'(press_count), 32'(m_count));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_ready", 32'(kif.code_ready), 32'd0);
    check("rst_outs", 32'(pack(press_count, cur_code, cur_ext, key_held, disp_en)), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    clrn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(kif.code_ready), 32'd1);
  endtask

  logic [7:0] rnd_set[5];

  initial begin
    clrn = 1'b0;
    count_clr = 1'b0;
    kif.code_data = 8'h00;
    kif.code_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // basic make / break
    send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    // typematic repeats
    send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    clr_pulse();
    // extended key; plain break of same code is ignored
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hF0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    // malformed F0 E0 dropped, then a normal make
    send(8'hF0, 1'b0); send(8'hE0, 1'b0); send(8'h29, 1'b0);
    // a different key while one is held; the old break is then ignored
    send(8'h2A, 1'b0); send(8'hF0, 1'b0); send(8'h29, 1'b0);
    send(8'hF0, 1'b0); send(8'h2A, 1'b0);

    // fill the counter to MAX_COUNT, then one more press
    clr_pulse();
    for (int i = 0; i < MAX_COUNT; i++) begin
      send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    end
    check("count_at_max", 32'(press_count), 32'(MAX_COUNT));
    send(8'h1C, 1'b0);
`ifdef PRESS_SAT_EN
    check("count_after_max", 32'(press_count), 32'(MAX_COUNT));
`else
    check("count_after_max", 32'(press_count), 32'd0);
`endif
    // clear coinciding with a counting commit
    send(8'h2A, 1'b1);
    check("clr_vs_commit", 32'(press_count), 32'd0);

    // reset while in the E0 state discards the prefix
    send(8'hE0, 1'b0);
    do_reset();
    send(8'h74, 1'b0);
    check("post_rst_ext", 32'(cur_ext), 32'd0);

    // random byte soak
    rnd_set[0] = 8'h1C; rnd_set[1] = 8'h2A; rnd_set[2] = 8'hE0;
    rnd_set[3] = 8'hF0; rnd_set[4] = 8'h75;
    for (int i = 0; i < 80; i++) begin
      send(rnd_set[$urandom_range(0, 4)], ($urandom_range(0, 9) == 0));
    end

    if (exp_q.size() != 0) check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
